// File: rtl/usm_avmm_burst_splitter.sv
// Splits kernel USM AVMM bursts into sub-bursts of at most BURSTCOUNT_MAX beats that never
// cross a PAGE_BYTES boundary; read responses come back in order through one register stage.
module usm_avmm_burst_splitter #(
  parameter int unsigned ADDR_WIDTH       = 48,
  parameter int unsigned DATA_WIDTH       = 512,
  parameter int unsigned BYTEENABLE_WIDTH = 64,
  parameter int unsigned BURSTCOUNT_WIDTH = 5,
  parameter int unsigned BURSTCOUNT_MAX   = 16,
  parameter int unsigned PAGE_BYTES       = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       s_address,
  input  logic                        s_read,
  input  logic                        s_write,
  input  logic [BURSTCOUNT_WIDTH-1:0] s_burstcount,
  input  logic [DATA_WIDTH-1:0]       s_writedata,
  input  logic [BYTEENABLE_WIDTH-1:0] s_byteenable,
  output logic                        s_waitrequest,
  output logic [DATA_WIDTH-1:0]       s_readdata,
  output logic                        s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]       m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]       m_writedata,
  output logic [BYTEENABLE_WIDTH-1:0] m_byteenable,
  input  logic                        m_waitrequest,
  input  logic [DATA_WIDTH-1:0]       m_readdata,
  input  logic                        m_readdatavalid,
  output logic                        err_zero_burst
);

  localparam int unsigned PageLog2 = $clog2(PAGE_BYTES);

  typedef enum logic [1:0] {StIdle, StRdIssue, StWrData} state_e;

  state_e                        state_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [BURSTCOUNT_WIDTH-1:0]   remaining_q;
  logic [BURSTCOUNT_WIDTH-1:0]   beat_cnt_q;
  logic                          err_q;
  logic                          rvalid_q;
  logic [DATA_WIDTH-1:0]         rdata_q;

  logic [31:0]                   beats_to_page;
  logic [BURSTCOUNT_WIDTH-1:0]   chunk;
  logic [ADDR_WIDTH-1:0]         addr_step;
  logic                          last_chunk;
  logic                          cmd_zero;
  logic                          wr_beat;
  logic                          wr_sub_done;
  logic                          unused_addr_bits;

  assign unused_addr_bits = ^s_address[5:0];

  // Chunk derives only from registered state so m_burstcount is stable for a whole sub-burst.
  always_comb begin
    beats_to_page = (PAGE_BYTES - 32'(addr_q[PageLog2-1:0])) >> 6;
    chunk         = remaining_q;
    if (BURSTCOUNT_MAX < 32'(chunk)) chunk = BURSTCOUNT_WIDTH'(BURSTCOUNT_MAX);
    if (beats_to_page < 32'(chunk))  chunk = BURSTCOUNT_WIDTH'(beats_to_page);
  end

  assign addr_step   = ADDR_WIDTH'(chunk) << 6;
  assign last_chunk  = (chunk == remaining_q);
  assign cmd_zero    = (s_read || s_write) && (s_burstcount == '0);
  assign wr_beat     = (state_q == StWrData) && s_write && !m_waitrequest;
  assign wr_sub_done = (beat_cnt_q == chunk - BURSTCOUNT_WIDTH'(1));

  assign m_address       = addr_q;
  assign m_burstcount    = chunk;
  assign m_writedata     = s_writedata;
  assign m_byteenable    = s_byteenable;
  assign m_read          = (state_q == StRdIssue);
  assign m_write         = (state_q == StWrData) && s_write;
  assign err_zero_burst  = err_q;
  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rvalid_q;

  always_comb begin
    s_waitrequest = 1'b1;
    if (!reset) begin
      case (state_q)
        StIdle:    s_waitrequest = !cmd_zero;
        StRdIssue: s_waitrequest = !(!m_waitrequest && last_chunk);
        StWrData:  s_waitrequest = m_waitrequest;
        default:   s_waitrequest = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (s_read || s_write) begin
            if (s_burstcount == '0) begin
              err_q <= 1'b1;
            end else begin
              addr_q      <= {s_address[ADDR_WIDTH-1:6], 6'b0};
              remaining_q <= s_burstcount;
              beat_cnt_q  <= '0;
              state_q     <= s_read ? StRdIssue : StWrData;
            end
          end
        end
        StRdIssue: begin
          if (!m_waitrequest) begin
            addr_q      <= addr_q + addr_step;
            remaining_q <= remaining_q - chunk;
            if (last_chunk) state_q <= StIdle;
          end
        end
        StWrData: begin
          // remaining_q drops per sub-burst so chunk stays fixed while its beats flow
          if (wr_beat) begin
            if (wr_sub_done) begin
              addr_q      <= addr_q + addr_step;
              remaining_q <= remaining_q - chunk;
              beat_cnt_q  <= '0;
              if (last_chunk) state_q <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + BURSTCOUNT_WIDTH'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= m_readdatavalid;
      rdata_q  <= m_readdata;
    end
  end

endmodule

// File: tb/tb_usm_avmm_burst_splitter.sv
// Directed bench for usm_avmm_burst_splitter: table of commands with hand-computed sub-bursts,
// plus hand-written stall/bubble, zero-burst and mid-burst reset sequences.
module tb_usm_avmm_burst_splitter;

  localparam int AW = 48;
  localparam int DW = 512;
  localparam int BEW = 64;
  localparam int BCW = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  s_address = '0;
  logic           s_read = 1'b0;
  logic           s_write = 1'b0;
  logic [BCW-1:0] s_burstcount = '0;
  logic [DW-1:0]  s_writedata = '0;
  logic [BEW-1:0] s_byteenable = '0;
  logic           s_waitrequest;
  logic [DW-1:0]  s_readdata;
  logic           s_readdatavalid;
  logic [AW-1:0]  m_address;
  logic           m_read;
  logic           m_write;
  logic [BCW-1:0] m_burstcount;
  logic [DW-1:0]  m_writedata;
  logic [BEW-1:0] m_byteenable;
  logic           m_waitrequest = 1'b0;
  logic [DW-1:0]  m_readdata = '0;
  logic           m_readdatavalid = 1'b0;
  logic           err_zero_burst;

  int total = 0;
  int bad = 0;

  usm_avmm_burst_splitter dut (
    .clk            (clk),
    .reset          (reset),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_burstcount   (s_burstcount),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_burstcount   (m_burstcount),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .err_zero_burst (err_zero_burst)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    int            bc;
    int            n;
    logic [AW-1:0] a0, a1, a2;
    int            l0, l1, l2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low word 0x%0h want low word 0x%0h", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [AW-1:0] sub_a(input vec_t v, input int k);
    case (k)
      0: return v.a0;
      1: return v.a1;
      2: return v.a2;
      default: return '1;
    endcase
  endfunction

  function automatic int sub_l(input vec_t v, input int k);
    case (k)
      0: return v.l0;
      1: return v.l1;
      2: return v.l2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [DW-1:0] wdata(input int b);
    return {16{32'hC0DE_0000 | 32'(b)}};
  endfunction

  function automatic logic [BEW-1:0] wbe(input int b);
    return 64'hFFFF_FFFF_0000_0000 | 64'(b);
  endfunction

  function automatic logic [DW-1:0] rpat(input int s);
    return {16{32'hBEEF_0000 | 32'(s)}};
  endfunction

  // Downstream read responder and in-order return checker.
  int pending = 0;
  int seq = 0;
  int ret_seq = 0;
  int ret_cnt = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pending = 0;
      m_readdatavalid = 1'b0;
      prev_v = 1'b0;
      ret_seq = seq;
    end else begin
      if (prev_v || s_readdatavalid) begin
        chk("rd_valid_latency", 64'(s_readdatavalid), 64'(prev_v));
        if (s_readdatavalid) begin
          chk_data("rd_data_order", s_readdata, rpat(ret_seq));
          ret_seq++;
          ret_cnt++;
        end
      end
      if (pending > 0) begin
        m_readdatavalid = 1'b1;
        m_readdata = rpat(seq);
        seq++;
        pending--;
      end else begin
        m_readdatavalid = 1'b0;
      end
      prev_v = m_readdatavalid;
      #2;
      if (m_read && !m_waitrequest) pending += int'(m_burstcount);
    end
  end

  task automatic run_read(input vec_t v);
    int k = 0;
    int cyc = 0;
    int start = ret_cnt;
    bit done = 0;
    @(negedge clk);
    s_address = v.addr;
    s_burstcount = BCW'(v.bc);
    s_read = 1'b1;
    while (!done && cyc < 200) begin
      #1;
      if (m_read && !m_waitrequest) begin
        chk("rd_sub_addr", 64'(m_address), 64'(sub_a(v, k)));
        chk("rd_sub_len", 64'(m_burstcount), 64'(sub_l(v, k)));
        k++;
      end
      if (!s_waitrequest) begin
        done = 1;
        chk("rd_accept_on_last_sub", 64'(k), 64'(v.n));
      end
      cyc++;
      @(negedge clk);
    end
    s_read = 1'b0;
    chk("rd_cmd_accepted", 64'(done), 64'd1);
    chk("rd_sub_count", 64'(k), 64'(v.n));
    cyc = 0;
    while (ret_cnt - start < v.bc && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("rd_return_count", 64'(ret_cnt - start), 64'(v.bc));
  endtask

  task automatic run_write(input vec_t v, input int stall_beat, input int bubble_beat);
    int beat = 0;
    int si = 0;
    int wc = 0;
    int cyc = 0;
    int xfers = 0;
    int stall_n = 0;
    bit bubbled = 0;
    s_address = v.addr;
    s_burstcount = BCW'(v.bc);
    while (beat < v.bc && cyc < 300) begin
      @(negedge clk);
      cyc++;
      m_waitrequest = (beat == stall_beat && stall_n < 3);
      if (m_waitrequest) stall_n++;
      if (beat == bubble_beat && !bubbled) begin
        s_write = 1'b0;
        bubbled = 1;
      end else begin
        s_write = 1'b1;
        s_writedata = wdata(beat);
        s_byteenable = wbe(beat);
      end
      #1;
      if (m_write && !m_waitrequest) xfers++;
      if (s_write && !s_waitrequest) begin
        chk("wr_beat_addr", 64'(m_address), 64'(sub_a(v, si)));
        chk("wr_beat_len", 64'(m_burstcount), 64'(sub_l(v, si)));
        chk_data("wr_beat_data", m_writedata, wdata(beat));
        chk("wr_beat_be", m_byteenable, wbe(beat));
        beat++;
        wc++;
        if (wc == sub_l(v, si)) begin
          si++;
          wc = 0;
        end
      end
    end
    @(negedge clk);
    s_write = 1'b0;
    m_waitrequest = 1'b0;
    chk("wr_beats_done", 64'(beat), 64'(v.bc));
    chk("wr_master_xfers", 64'(xfers), 64'(v.bc));
    chk("wr_sub_count", 64'(si), 64'(v.n));
  endtask

  task automatic run_vec(input vec_t v, input int stall_beat, input int bubble_beat);
    if (v.wr) run_write(v, stall_beat, bubble_beat);
    else run_read(v);
  endtask

  initial begin
    vec_t sv;
    int mact;
    int beat;
    int cyc;
    bit got;

    //        wr addr        bc  n  a0         a1         a2         l0  l1  l2
    vecs[0] = '{0, 48'h0,    31, 2, 48'h0,     48'h400,   48'h0,     16, 15, 0};
    vecs[1] = '{0, 48'hFC0,  8,  2, 48'hFC0,   48'h1000,  48'h0,     1,  7,  0};
    vecs[2] = '{1, 48'hF00,  20, 2, 48'hF00,   48'h1000,  48'h0,     4,  16, 0};
    vecs[3] = '{0, 48'h2000, 3,  1, 48'h2000,  48'h0,     48'h0,     3,  0,  0};
    vecs[4] = '{1, 48'h1FC0, 2,  2, 48'h1FC0,  48'h2000,  48'h0,     1,  1,  0};
    vecs[5] = '{1, 48'h107,  5,  1, 48'h100,   48'h0,     48'h0,     5,  0,  0};
    vecs[6] = '{0, 48'hE00,  31, 3, 48'hE00,   48'h1000,  48'h1400,  8,  16, 7};
    vecs[7] = '{1, 48'h3C0,  31, 2, 48'h3C0,   48'h7C0,   48'h0,     16, 15, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_waitrequest", 64'(s_waitrequest), 64'd1);
    chk("rst_m_read", 64'(m_read), 64'd0);
    chk("rst_m_write", 64'(m_write), 64'd0);
    chk("rst_s_readdatavalid", 64'(s_readdatavalid), 64'd0);
    chk("rst_err_zero_burst", 64'(err_zero_burst), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], -1, -1);

    // 16-beat write with 3 stall cycles at beat 5 and a kernel bubble at beat 10.
    sv = '{1, 48'h0, 16, 1, 48'h0, 48'h0, 48'h0, 16, 0, 0};
    run_write(sv, 5, 10);

    // Zero-length command is consumed with no master activity.
    @(negedge clk);
    s_address = 48'h40;
    s_burstcount = '0;
    s_read = 1'b1;
    mact = 0;
    got = 0;
    cyc = 0;
    while (!got && cyc < 5) begin
      #1;
      if (m_read || m_write) mact++;
      if (!s_waitrequest) got = 1;
      cyc++;
      @(negedge clk);
    end
    s_read = 1'b0;
    repeat (3) begin
      #1;
      if (m_read || m_write) mact++;
      @(negedge clk);
    end
    chk("zero_cmd_consumed", 64'(got), 64'd1);
    chk("zero_no_master_activity", 64'(mact), 64'd0);
    chk("zero_err_set", 64'(err_zero_burst), 64'd1);
    run_vec(vecs[3], -1, -1);
    chk("zero_err_sticky", 64'(err_zero_burst), 64'd1);

    // Reset lands while beat 7 of a 16-beat write is on the bus.
    s_address = 48'h0;
    s_burstcount = 5'd16;
    beat = 0;
    cyc = 0;
    while (beat < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      s_write = 1'b1;
      s_writedata = wdata(beat);
      s_byteenable = wbe(beat);
      #1;
      if (s_write && !s_waitrequest) beat++;
    end
    chk("rstmid_reached_beat7", 64'(beat), 64'd6);
    @(negedge clk);
    s_writedata = wdata(6);
    s_byteenable = wbe(6);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_m_write", 64'(m_write), 64'd0);
    chk("rstmid_s_readdatavalid", 64'(s_readdatavalid), 64'd0);
    chk("rstmid_s_waitrequest", 64'(s_waitrequest), 64'd1);
    chk("rstmid_err_cleared", 64'(err_zero_burst), 64'd0);
    @(negedge clk);
    s_write = 1'b0;
    reset = 1'b0;
    sv = '{0, 48'h2000, 16, 1, 48'h2000, 48'h0, 48'h0, 16, 0, 0};
    run_vec(sv, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
